mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM pipeline interface: takes the EX/MEM register outputs, executes the memory access against a variable-latency data memory over a req/ack handshake, and registers the MEM/WB pipeline outputs.
- Stalls the front of the pipeline, including EX/MEM, while an access is outstanding.
- Aborts a hung access after a bounded wait and reports it.

Parameters:
DATA_W, 32, width of ALU result, store data, load data and memory address
RD_W, 5, destination register index width
WB_W, 4, write-back control bundle width; bit 0 is RegWrite
ACK_TIMEOUT, 15, max cycles in WAIT without dm_ack before abort (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low
MemWb  in  WB_W  write-back control from EX/MEM
MemMem  in  2  memory control from EX/MEM: [1]=MemRead, [0]=MemWrite
MemAluRes  in  DATA_W  ALU result / memory address
MemWriteD  in  DATA_W  store data
MemRd  in  RD_W  destination register
dm_req  out  1  memory request, high for the whole WAIT state
dm_we  out  1  1=write, 0=read; valid while dm_req
dm_addr  out  DATA_W  = MemAluRes while dm_req, else 0
dm_wdata  out  DATA_W  = MemWriteD while dm_req && dm_we, else 0
dm_ack  in  1  memory completion, sampled only in WAIT
dm_rdata  in  DATA_W  load data, valid in the dm_ack cycle
mem_stall  out  1  hold PC/IF-ID/ID-EX/EX-MEM this cycle
mem_err  out  1  one-cycle pulse: access aborted by timeout
WbWb  out  WB_W  registered write-back control
WbReadData  out  DATA_W  registered load data
WbAluRes  out  DATA_W  registered ALU result
WbRd  out  RD_W  registered destination register

Behaviour:
- Reset (rst=0 at edge):
  - State goes to IDLE and the timeout counter clears.
  - WbWb, WbReadData, WbAluRes, WbRd and mem_err all reset to 0.
  - dm_req, dm_we, dm_addr, dm_wdata and mem_stall are decoded from state and inputs, so they read 0 from the first cycle after the reset edge.
  - Reset in WAIT abandons the access with no mem_err pulse.
- op = MemMem != 0. A value of 2'b11 is treated as a write: dm_we=1 and load data is ignored.
- FSM states: IDLE and WAIT.
- IDLE, op=0:
  - mem_stall=0.
  - At the edge, MEM/WB loads pass-through values: WbWb=MemWb, WbAluRes=MemAluRes, WbRd=MemRd, WbReadData=0. Latency is 1 cycle.
- IDLE, op=1:
  - mem_stall=1.
  - MEM/WB loads a bubble: WbWb=0, WbRd=0; WbAluRes and WbReadData hold.
  - Next state WAIT, counter=0.
- WAIT, dm_ack=1:
  - mem_stall=0.
  - MEM/WB loads WbWb=MemWb, WbAluRes=MemAluRes, WbRd=MemRd, and WbReadData=dm_rdata (read) or 0 (write).
  - Next state IDLE. Minimum memory-op latency is 2 cycles.
- WAIT, dm_ack=0, counter < ACK_TIMEOUT-1:
  - mem_stall=1, bubble into MEM/WB, counter increments.
- WAIT, dm_ack=0, counter == ACK_TIMEOUT-1 (abort):
  - mem_stall=0; dm_req stays high this cycle.
  - MEM/WB loads WbWb=MemWb with bit0 cleared, so no register write. WbRd=MemRd, WbAluRes=MemAluRes, WbReadData=0.
  - mem_err=1 for the next cycle only. Next state IDLE.
- dm_ack and the abort condition in the same cycle: ack wins, normal completion, no mem_err.
- dm_ack outside WAIT is ignored.
- EX/MEM holds its contents while mem_stall=1, so the request fields stay stable across WAIT.
- A back-to-back memory op re-enters WAIT after one IDLE cycle.
- Counter width is clog2(ACK_TIMEOUT)+1. It never wraps because it clears on entering WAIT.

Decomposition:
- Shared pipeline package holds:
  - MemMem bit indices (MEM_READ=1, MEM_WRITE=0)
  - WB_REGWRITE bit index 0
  - FSM state encoding (IDLE=0, WAIT=1)
  - default widths
- One sub-module, mem_ack_timer: counter with clear, enable and expired outputs, parameterised by ACK_TIMEOUT.
- The rest is flat.

Test Plan:
- Reset then ALU op: rst=0 for 2 cycles, then MemMem=0, MemWb=4'b0001, MemAluRes=0x1234, MemRd=7 → one edge later WbWb=1, WbAluRes=0x1234, WbRd=7, WbReadData=0, mem_stall never high.
- Load, ack on 3rd WAIT cycle: MemMem=2'b10, addr 0x40, dm_rdata=0xDEADBEEF → mem_stall high 3 cycles, dm_req high 3 cycles with dm_addr=0x40 and dm_we=0, then WbReadData=0xDEADBEEF, WbWb=MemWb, preceded by 3 bubble cycles with WbWb=0.
- Store with immediate ack: MemMem=2'b01, addr 0x80, data 0xA5A5A5A5 → dm_req 1 cycle with dm_we=1 and dm_wdata=0xA5A5A5A5, total stall 1 cycle, WbReadData=0.
- Timeout, ACK_TIMEOUT=4, no ack: dm_req high exactly 4 cycles, then mem_err pulses 1 cycle, WbWb bit0=0, FSM returns to IDLE and the next ALU op passes normally.
- Ack on the final timeout cycle: ack at WAIT cycle 4 → normal completion, mem_err stays 0.
- Reset mid-WAIT: rst=0 during 2nd WAIT cycle → next cycle dm_req=0, mem_stall=0, all Wb* outputs=0, mem_err=0.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions for the MEM/WB stage.
package mem_wb_stage_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_RD_W   = 5;
   localparam int DEF_WB_W   = 4;
   localparam int DEF_ACK_TO = 15;

   localparam int MEM_READ    = 1;
   localparam int MEM_WRITE   = 0;
   localparam int WB_REGWRITE = 0;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } mem_state_e;

endpackage

// File: rtl/mem_wb_stage_ack_timer.sv
// Bounded-wait counter for an outstanding data memory access.
module mem_ack_timer #(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = $clog2(ACK_TIMEOUT) + 1;
   localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage access sequencer and MEM/WB pipeline register.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int RD_W        = DEF_RD_W,
   parameter int WB_W        = DEF_WB_W,
   parameter int ACK_TIMEOUT = DEF_ACK_TO
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WB_W-1:0]   MemWb,
   input  logic [1:0]        MemMem,
   input  logic [DATA_W-1:0] MemAluRes,
   input  logic [DATA_W-1:0] MemWriteD,
   input  logic [RD_W-1:0]   MemRd,
   output logic              dm_req,
   output logic              dm_we,
   output logic [DATA_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic              dm_ack,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic              mem_stall,
   output logic              mem_err,
   output logic [WB_W-1:0]   WbWb,
   output logic [DATA_W-1:0] WbReadData,
   output logic [DATA_W-1:0] WbAluRes,
   output logic [RD_W-1:0]   WbRd
);

   mem_state_e        state_q, state_d;
   logic [WB_W-1:0]   wb_q, wb_d;
   logic [DATA_W-1:0] rdat_q, rdat_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic [RD_W-1:0]   rd_q, rd_d;
   logic              err_q, err_d;
   logic              op, is_wr;
   logic              tmr_clr, tmr_en, tmr_exp;

   // 2'b11 counts as a store
   assign op    = MemMem[MEM_READ] | MemMem[MEM_WRITE];
   assign is_wr = MemMem[MEM_WRITE];

   mem_ack_timer #(
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (tmr_clr),
      .en_i     (tmr_en),
      .expired_o(tmr_exp)
   );

   always_comb begin
      state_d   = state_q;
      wb_d      = wb_q;
      rdat_d    = rdat_q;
      alu_d     = alu_q;
      rd_d      = rd_q;
      err_d     = 1'b0;
      mem_stall = 1'b0;
      tmr_clr   = 1'b0;
      tmr_en    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            tmr_clr = 1'b1;
            if (op) begin
               mem_stall = 1'b1;
               wb_d      = '0;
               rd_d      = '0;
               state_d   = S_WAIT;
            end else begin
               wb_d   = MemWb;
               alu_d  = MemAluRes;
               rd_d   = MemRd;
               rdat_d = '0;
            end
         end
         S_WAIT: begin
            if (dm_ack) begin
               wb_d    = MemWb;
               alu_d   = MemAluRes;
               rd_d    = MemRd;
               rdat_d  = is_wr ? '0 : dm_rdata;
               state_d = S_IDLE;
            end else if (tmr_exp) begin
               // Abort: retire the op but suppress the register write
               wb_d              = MemWb;
               wb_d[WB_REGWRITE] = 1'b0;
               alu_d             = MemAluRes;
               rd_d              = MemRd;
               rdat_d            = '0;
               err_d             = 1'b1;
               state_d           = S_IDLE;
            end else begin
               mem_stall = 1'b1;
               tmr_en    = 1'b1;
               wb_d      = '0;
               rd_d      = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         wb_q    <= '0;
         rdat_q  <= '0;
         alu_q   <= '0;
         rd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wb_q    <= wb_d;
         rdat_q  <= rdat_d;
         alu_q   <= alu_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
      end
   end

   assign dm_req     = (state_q == S_WAIT);
   assign dm_we      = dm_req & is_wr;
   assign dm_addr    = dm_req ? MemAluRes : '0;
   assign dm_wdata   = dm_we ? MemWriteD : '0;
   assign mem_err    = err_q;
   assign WbWb       = wb_q;
   assign WbReadData = rdat_q;
   assign WbAluRes   = alu_q;
   assign WbRd       = rd_q;

endmodule
